// File: rtl/push_debouncer.sv
// push_debouncer: counter-FSM button debouncer; in clk, rst, sypush (synced level), en (press enable); out level, press/rel strobes, press_count
module push_debouncer #(
    parameter int DEBOUNCE = 250000,
    parameter int CNT_W    = 18,
    parameter int PC_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sypush,
    input  logic            en,
    output logic            level,
    output logic            press,
    output logic            rel,
    output logic [PC_W-1:0] press_count
);
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic done;
    assign done = cnt == CNT_W'(DEBOUNCE - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            rel         <= 1'b0;
            press_count <= '0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                IDLE: begin
                    state <= sypush ? PRESS_CHK : IDLE;
                    cnt   <= sypush ? CNT_W'(1) : '0;
                end
                PRESS_CHK: begin
                    if (!sypush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (done) begin
                        state       <= HELD;
                        cnt         <= '0;
                        level       <= 1'b1;
                        press       <= en;
                        press_count <= press_count + PC_W'(en);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    state <= sypush ? HELD : REL_CHK;
                    cnt   <= sypush ? '0 : CNT_W'(1);
                end
                REL_CHK: begin
                    if (sypush) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_push_debouncer.sv
// tb_push_debouncer: directed and random checks of push_debouncer against a run-length reference model
module tb_push_debouncer;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int PW = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sypush = 1'b0;
    logic en = 1'b1;
    logic level, press, rel;
    logic [PW-1:0] press_count;
    int errors = 0;
    int checks = 0;
    int m_lvl = 0;
    int m_run = 0;
    int m_cnt = 0;
    int m_press = 0;
    int m_rel = 0;
    push_debouncer #(.DEBOUNCE(D), .CNT_W(CW), .PC_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .sypush(sypush),
        .en(en),
        .level(level),
        .press(press),
        .rel(rel),
        .press_count(press_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    // Model: the level flips once D consecutive samples disagree with it.
    task automatic step(input logic s, input logic e, input logic r);
        sypush = s;
        en = e;
        rst = r;
        @(posedge clk);
        m_press = 0;
        m_rel = 0;
        if (r) begin
            m_lvl = 0;
            m_run = 0;
            m_cnt = 0;
        end else begin
            m_run = (int'(s) != m_lvl) ? m_run + 1 : 0;
            if (m_run == D) begin
                m_run = 0;
                m_lvl = 1 - m_lvl;
                if (m_lvl == 1) begin
                    m_press = int'(e);
                    if (e) m_cnt = (m_cnt + 1) % (1 << PW);
                end else begin
                    m_rel = 1;
                end
            end
        end
        #1;
        chk("level", 32'(level), 32'(m_lvl));
        chk("press", 32'(press), 32'(m_press));
        chk("release", 32'(rel), 32'(m_rel));
        chk("press_count", 32'(press_count), 32'(m_cnt));
    endtask
    initial begin
        int hold;
        logic v;
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("reset_level", 32'(level), 0);
        chk("reset_count", 32'(press_count), 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == 3) chk("clean_press_e4", 32'(press), 1);
            if (i == 4) chk("clean_press_e5", 32'(press), 0);
        end
        chk("clean_count", 32'(press_count), 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 3) chk("clean_release", 32'(rel), 1);
        end
        chk("clean_level_low", 32'(level), 0);
        for (int i = 0; i < 11; i++) begin
            v = (i == 3 || i == 6) ? 1'b0 : 1'b1;
            step(v, 1'b1, 1'b0);
            if (i < 10) chk("bounce_no_early", 32'(press), 0);
        end
        chk("bounce_press", 32'(press), 1);
        chk("bounce_count", 32'(press_count), 2);
        for (int i = 0; i < 8; i++) begin
            step((i < 3) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            chk("glitch_no_release", 32'(rel), 0);
            chk("glitch_level", 32'(level), 1);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("masked_press", 32'(press), 0);
        end
        chk("masked_level", 32'(level), 1);
        chk("masked_count", 32'(press_count), 2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
            chk("wrap_count", 32'(press_count), 32'((3 + p) % 4));
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_level", 32'(level), 0);
        chk("rst_press", 32'(press), 0);
        chk("rst_release", 32'(rel), 0);
        chk("rst_count", 32'(press_count), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("post_rst_press", 32'(press), 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        hold = 0;
        v = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                v = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            step(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) == 0));
            chk("strobe_exclusive", 32'(press & rel), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/push_debouncer.md
# push_debouncer

Consumer end of the push-button input path. Takes the already-synchronized button level `sypush` and filters contact bounce with a per-button counter FSM. Produces a clean level, one-cycle press/release strobes, and a running press count for the game logic. One instance sits per player button, directly after that button's synchronizer.

## Interface
Parameters:
- `DEBOUNCE`, 250000: consecutive agreeing samples needed to accept a level change; legal range ≥ 2 (5 ms at 50 MHz).
- `CNT_W`, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE.
- `PC_W`, 8: width of `press_count`.

Ports:
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sypush`, in, 1: synchronized button level; 1 = pressed.
- `en`, in, 1: press-strobe enable; 0 masks `press` and count updates (between rounds).
- `level`, out, 1: debounced button level, registered.
- `press`, out, 1: one-cycle strobe on an accepted 0→1 change, gated by `en`.
- `release`, out, 1: one-cycle strobe on an accepted 1→0 change, never gated.
- `press_count`, out, PC_W: number of `press` strobes since reset, modulo 2^PC_W.

## Operation
- The FSM has four states: IDLE (level 0), PRESS_CHK, HELD (level 1), REL_CHK. There is one counter `cnt`.
- IDLE:
  - `sypush`=1 → PRESS_CHK, `cnt`←1.
  - Otherwise stay, `cnt`←0.
- PRESS_CHK:
  - `sypush`=0 → IDLE, `cnt`←0 (glitch rejected, no strobe).
  - `sypush`=1 and `cnt`=DEBOUNCE−1 → HELD, `level`←1, `press`←`en`, and `press_count` increments if `en`=1.
  - Otherwise `cnt`←`cnt`+1.
- HELD:
  - `sypush`=0 → REL_CHK, `cnt`←1.
  - Otherwise stay, `cnt`←0.
- REL_CHK:
  - `sypush`=1 → HELD, `cnt`←0 (no strobe).
  - `sypush`=0 and `cnt`=DEBOUNCE−1 → IDLE, `level`←0, `release`←1.
  - Otherwise `cnt`←`cnt`+1.
- `press` and `release` are 0 in every cycle not named above. They are never high in the same cycle.
- `en` is sampled only on the accepting edge. A press accepted while `en`=0 is lost; it is not deferred. Its release still strobes.
- `press_count` wraps from 2^PC_W−1 to 0 without saturating.
- Reset (`rst`=1 at an edge, any state) sets: state IDLE, `cnt` 0, `level` 0, `press` 0, `release` 0, `press_count` 0. Reset has priority over all other inputs.
- A button held through reset is re-debounced from IDLE after reset deasserts and yields a fresh `press`.

## Timing
- Press latency: if `sypush` is 1 at edges E1..E_D (D=DEBOUNCE) and 0 at the edge before E1, then `level` and `press` go high after E_D. `press` is high for exactly one cycle.
- Release latency: symmetric, D consecutive 0 samples starting from HELD.
- Any opposing sample inside a CHK state aborts it. The counter restarts from 1 only on the next qualifying sample from the stable state.
- All outputs are registered; no combinational path from `sypush` or `en` to any output.
- `press_count` updates on the same edge that raises `press`.

## Test plan
- Clean press, DEBOUNCE=4, `en`=1: `sypush` 0→1 before E1, held 10 cycles. Required: `level`=1 and `press`=1 after E4, `press`=0 after E5, `press_count`=1. Then `sypush`→0 for 6 cycles. Required: `release`=1 exactly one cycle after the 4th zero sample, `level`=0.
- Bounce rejection, DEBOUNCE=4: `sypush` pattern 1,1,1,0,1,1,0,1,1,1,1. Required: `press` only after the final 4th consecutive 1. No earlier strobe. `press_count`=1.
- Release glitch: in HELD, `sypush` 0,0,0,1 then 1 steady. Required: no `release`, `level` stays 1.
- Enable masking: press accepted with `en`=0. Required: `level`=1, `press` never high, `press_count` unchanged. On release, `release` strobes once.
- Wrap and reset: PC_W=2, five accepted presses. Required: `press_count` sequence 1,2,3,0,1. Then assert `rst` mid-PRESS_CHK with `sypush` held 1. Required: all outputs 0 after the reset edge. A new `press` occurs DEBOUNCE edges after `rst` deasserts.
